// File: rtl/wgt_loader_pkg.sv
// rtl/wgt_loader_pkg.sv - shared types and default sizing for the weight loader
// Loader FSM states and the packer accumulator depth for the default configuration.
package wgt_loader_pkg;

   localparam int DEF_TN         = 14;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_IN_BYTES   = 4;
   localparam int ACC_BYTES      = DEF_TN + DEF_IN_BYTES - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BANK,
      ST_LOAD,
      ST_FLUSH,
      ST_DONE
   } state_e;

endpackage

// File: rtl/wgt_row_packer.sv
// rtl/wgt_row_packer.sv - byte accumulator that repacks stream beats into TN-byte rows
// Bytes above cnt are kept at zero so beats can be OR-ed in and partial rows come out zero padded.
module wgt_row_packer
   import wgt_loader_pkg::*;
#(
   parameter int TN       = DEF_TN,
   parameter int IN_BYTES = DEF_IN_BYTES,
   localparam int ACC     = TN + IN_BYTES - 1,
   localparam int CW      = $clog2(TN + IN_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  append,
   input  logic                  emit,
   input  logic [IN_BYTES*8-1:0] in_data,
   output logic [CW-1:0]         cnt,
   output logic [TN*8-1:0]       row_data
);

   logic [ACC*8-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ACC*8-1:0] ext;

   always_comb begin
      ext                     = '0;
      ext[IN_BYTES*8-1:0]     = in_data;
      acc_d                   = acc_q;
      cnt_d                   = cnt_q;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (emit) begin
         acc_d = acc_q >> (TN*8);
         cnt_d = cnt_q - CW'(TN);
      end else if (append) begin
         acc_d = acc_q | (ext << {cnt_q, 3'b000});
         cnt_d = cnt_q + CW'(IN_BYTES);
      end
   end

   always_comb begin
      row_data = '0;
      for (int i = 0; i < TN; i++) begin
         if (i < int'(cnt_q)) row_data[i*8 +: 8] = acc_q[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/wgt_loader.sv
// rtl/wgt_loader.sv - ping-pong weight SRAM producer: stream repacking, bank ownership, error flags
// Optional WGT_LOADER_CKSUM_EN adds a byte checksum of the last completed tile.
module wgt_loader
   import wgt_loader_pkg::*;
#(
   parameter int TN         = DEF_TN,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int IN_BYTES   = DEF_IN_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   cfg_rows,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IN_BYTES*8-1:0] s_data,
   input  logic                  s_last,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [TN*8-1:0]       wdata,
   output logic                  bank_sel_wr,
   output logic [1:0]            bank_valid,
   input  logic [1:0]            bank_release,
   output logic                  busy,
   output logic                  done,
   output logic                  err_short,
   output logic                  err_long
`ifdef WGT_LOADER_CKSUM_EN
   ,
   output logic [31:0]           cksum
`endif
);

   localparam int CW = $clog2(TN + IN_BYTES);
   localparam int RW = ADDR_WIDTH + 1;

   state_e                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic [RW-1:0]         rows_cfg_q, rows_cfg_d;
   logic [RW-1:0]         rows_q, rows_d;
   logic                  last_q, last_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [TN*8-1:0]       wdata_q, wdata_d;
   logic [1:0]            bank_valid_q, bank_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_short_q, err_short_d;
   logic                  err_long_q, err_long_d;

   logic                  pk_clear, pk_append, pk_emit;
   logic [CW-1:0]         pk_cnt;
   logic [TN*8-1:0]       pk_row;
   logic                  accept, rows_full, can_emit;

   wgt_row_packer #(.TN(TN), .IN_BYTES(IN_BYTES)) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (pk_clear),
      .append   (pk_append),
      .emit     (pk_emit),
      .in_data  (s_data),
      .cnt      (pk_cnt),
      .row_data (pk_row)
   );

   // Once s_last is taken no further beats belong to this tile.
   assign s_ready   = (state_q == ST_LOAD) && (pk_cnt < CW'(TN)) && !last_q;
   assign accept    = s_valid && s_ready;
   assign rows_full = (rows_q == rows_cfg_q);
   assign can_emit  = (pk_cnt >= CW'(TN)) && !rows_full;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rows_cfg_d   = rows_cfg_q;
      rows_d       = rows_q;
      last_d       = last_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      bank_valid_d = bank_valid_q & ~bank_release;
      done_d       = 1'b0;
      err_short_d  = err_short_q;
      err_long_d   = err_long_q;
      pk_clear     = 1'b0;
      pk_append    = 1'b0;
      pk_emit      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_WAIT_BANK;
               rows_cfg_d  = (cfg_rows == '0) ? RW'(1) : cfg_rows;
               rows_d      = '0;
               last_d      = 1'b0;
               err_short_d = 1'b0;
               err_long_d  = 1'b0;
               waddr_d     = '0;
               pk_clear    = 1'b1;
            end
         end
         ST_WAIT_BANK: begin
            if (!bank_valid_q[ptr_q]) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (can_emit) begin
               pk_emit = 1'b1;
               we_d    = 1'b1;
               waddr_d = rows_q[ADDR_WIDTH-1:0];
               wdata_d = pk_row;
               rows_d  = rows_q + RW'(1);
               if (last_q && (rows_q + RW'(1) == rows_cfg_q)) begin
                  state_d = ST_DONE;
                  if (pk_cnt != CW'(TN)) err_long_d = 1'b1;
               end
            end else if (last_q) begin
               if (rows_full) begin
                  state_d = ST_DONE;
                  if (pk_cnt != '0) err_long_d = 1'b1;
               end else begin
                  err_short_d = 1'b1;
                  state_d     = (pk_cnt != '0) ? ST_FLUSH : ST_DONE;
               end
            end else if (rows_full) begin
               // Tile already complete: drain and drop anything until s_last.
               pk_clear = 1'b1;
               if (accept || pk_cnt != '0) err_long_d = 1'b1;
               if (accept && s_last) state_d = ST_DONE;
            end else if (accept) begin
               pk_append = 1'b1;
               if (s_last) last_d = 1'b1;
            end
         end
         ST_FLUSH: begin
            we_d     = 1'b1;
            waddr_d  = rows_q[ADDR_WIDTH-1:0];
            wdata_d  = pk_row;
            rows_d   = rows_q + RW'(1);
            pk_clear = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            bank_valid_d[ptr_q] = 1'b1;
            done_d              = 1'b1;
            ptr_d               = ~ptr_q;
            pk_clear            = 1'b1;
            state_d             = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= 1'b0;
         rows_cfg_q   <= '0;
         rows_q       <= '0;
         last_q       <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         bank_valid_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_short_q  <= 1'b0;
         err_long_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rows_cfg_q   <= rows_cfg_d;
         rows_q       <= rows_d;
         last_q       <= last_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         bank_valid_q <= bank_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_short_q  <= err_short_d;
         err_long_q   <= err_long_d;
      end
   end

   assign we          = we_q;
   assign waddr       = waddr_q;
   assign wdata       = wdata_q;
   assign bank_sel_wr = ptr_q;
   assign bank_valid  = bank_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_short   = err_short_q;
   assign err_long    = err_long_q;

`ifdef WGT_LOADER_CKSUM_EN
   logic [31:0] sum_q, sum_d;
   logic [31:0] cksum_q, cksum_d;

   always_comb begin
      sum_d   = sum_q;
      cksum_d = cksum_q;
      if (state_q == ST_IDLE && start) sum_d = '0;
      if (we_d) begin
         for (int i = 0; i < TN; i++) sum_d = sum_d + 32'(wdata_d[i*8 +: 8]);
      end
      if (state_q == ST_DONE) cksum_d = sum_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         cksum_q <= '0;
      end else begin
         sum_q   <= sum_d;
         cksum_q <= cksum_d;
      end
   end

   assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_wgt_loader.sv
// tb/tb_wgt_loader.sv - scoreboard bench for wgt_loader
// Stimulus pushes expected row writes and done events; a monitor pops and compares.
module tb_wgt_loader;

   localparam int TN = 14;
   localparam int AW = 7;
   localparam int IB = 4;

   typedef struct {
      logic          bank;
      logic [AW-1:0] addr;
      logic [TN*8-1:0] data;
   } row_t;

   typedef struct {
      logic [1:0] bv;
      logic       es;
      logic       el;
   } done_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW:0]     cfg_rows = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic [IB*8-1:0] s_data = '0;
   logic            s_last = 1'b0;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [TN*8-1:0] wdata;
   logic            bank_sel_wr;
   logic [1:0]      bank_valid;
   logic [1:0]      bank_release = '0;
   logic            busy;
   logic            done;
   logic            err_short;
   logic            err_long;

   int checks = 0;
   int errors = 0;
   row_t  wq[$];
   done_t dq[$];

   wgt_loader #(.TN(TN), .ADDR_WIDTH(AW), .IN_BYTES(IB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_rows     (cfg_rows),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .we           (we),
      .waddr        (waddr),
      .wdata        (wdata),
      .bank_sel_wr  (bank_sel_wr),
      .bank_valid   (bank_valid),
      .bank_release (bank_release),
      .busy         (busy),
      .done         (done),
      .err_short    (err_short),
      .err_long     (err_long)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 128'(waddr), 128'h0);
               chk("unexpected_write_flag", 128'(we), 128'h0);
            end else begin
               row_t r;
               r = wq.pop_front();
               chk("waddr", 128'(waddr), 128'(r.addr));
               chk("wdata", 128'(wdata), 128'(r.data));
               chk("bank_sel_wr", 128'(bank_sel_wr), 128'(r.bank));
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 128'(done), 128'h0);
            end else begin
               done_t d;
               d = dq.pop_front();
               chk("bank_valid_at_done", 128'(bank_valid), 128'(d.bv));
               chk("err_short_at_done", 128'(err_short), 128'(d.es));
               chk("err_long_at_done", 128'(err_long), 128'(d.el));
               chk("busy_at_done", 128'(busy), 128'h0);
            end
         end
      end
   end

   task automatic expect_tile(input int cfg, input int nbytes, input logic bank, input logic [1:0] bv);
      int    full;
      int    nrows;
      row_t  r;
      done_t d;
      full  = cfg * TN;
      nrows = (nbytes >= full) ? cfg : (nbytes + TN - 1) / TN;
      for (int ri = 0; ri < nrows; ri++) begin
         r.bank = bank;
         r.addr = AW'(ri);
         r.data = '0;
         for (int i = 0; i < TN; i++) begin
            int k;
            k = ri * TN + i;
            if (k < nbytes) r.data[i*8 +: 8] = 8'(k);
         end
         wq.push_back(r);
      end
      d.bv = bv;
      d.es = (nbytes < full);
      d.el = (nbytes > full);
      dq.push_back(d);
   endtask

   task automatic start_tile(input int cfg);
      cfg_rows = (AW+1)'(cfg);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input int b, input logic last);
      int n;
      for (int j = 0; j < IB; j++) s_data[j*8 +: 8] = 8'(b * IB + j);
      s_last  = last;
      s_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready && n < 300);
      if (n >= 300) chk("beat_accept_timeout", 128'(s_ready), 128'h1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_tile(input int nbeats, input bit gaps);
      for (int b = 0; b < nbeats; b++) begin
         send_beat(b, b == nbeats - 1);
         if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((wq.size() != 0 || dq.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, 128'(wq.size() + dq.size()), 128'h0);
      @(posedge clk); #1;
   endtask

   task automatic release_banks(input logic [1:0] m);
      bank_release = m;
      @(posedge clk); #1;
      bank_release = '0;
      @(posedge clk); #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_we"}, 128'(we), 128'h0);
      chk({tag, "_busy"}, 128'(busy), 128'h0);
      chk({tag, "_done"}, 128'(done), 128'h0);
      chk({tag, "_bank_valid"}, 128'(bank_valid), 128'h0);
      chk({tag, "_s_ready"}, 128'(s_ready), 128'h0);
      chk({tag, "_err_short"}, 128'(err_short), 128'h0);
      chk({tag, "_err_long"}, 128'(err_long), 128'h0);
      chk({tag, "_waddr"}, 128'(waddr), 128'h0);
      chk({tag, "_wdata"}, 128'(wdata), 128'h0);
      chk({tag, "_bank_sel"}, 128'(bank_sel_wr), 128'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // exact tile into bank 0
      expect_tile(2, 28, 1'b0, 2'b01);
      start_tile(2);
      send_tile(7, 1'b0);
      wait_drain("exact_tile_drain");

      // second tile into bank 1
      expect_tile(2, 28, 1'b1, 2'b11);
      start_tile(2);
      send_tile(7, 1'b0);
      wait_drain("pingpong_drain");

      // both banks full: third tile stalls until bank 0 is released
      start_tile(2);
      repeat (4) @(negedge clk);
      chk("stall_busy", 128'(busy), 128'h1);
      chk("stall_s_ready", 128'(s_ready), 128'h0);
      chk("stall_bank_sel", 128'(bank_sel_wr), 128'h0);
      @(posedge clk); #1;
      expect_tile(2, 28, 1'b0, 2'b11);
      bank_release = 2'b01;
      @(posedge clk); #1;
      bank_release = '0;
      send_tile(7, 1'b0);
      wait_drain("stall_drain");

      release_banks(2'b11);
      chk("release_both", 128'(bank_valid), 128'h0);

      // short tile: 20 bytes into two rows
      expect_tile(2, 20, 1'b1, 2'b10);
      start_tile(2);
      send_tile(5, 1'b0);
      wait_drain("short_drain");
      chk("short_err_sticky", 128'(err_short), 128'h1);

      // long tile with gaps: one row, remainder dropped
      expect_tile(1, 24, 1'b0, 2'b11);
      start_tile(1);
      send_tile(6, 1'b1);
      wait_drain("long_drain");
      chk("long_err_sticky", 128'(err_long), 128'h1);

      release_banks(2'b11);
      chk("release_both_2", 128'(bank_valid), 128'h0);

      // release of bank 1 in its own DONE cycle: set wins
      expect_tile(2, 28, 1'b1, 2'b10);
      start_tile(2);
      chk("start_clears_err_short", 128'(err_short), 128'h0);
      chk("start_clears_err_long", 128'(err_long), 128'h0);
      fork
         send_tile(7, 1'b0);
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(we && waddr == AW'(1)) && n < 300);
            chk("done_cycle_sync", 128'(n < 300), 128'h1);
            bank_release = 2'b10;
            @(posedge clk); #1;
            bank_release = '0;
         end
      join
      wait_drain("setwins_drain");
      @(negedge clk);
      chk("setwins_bank_valid", 128'(bank_valid), 128'h2);
      @(posedge clk); #1;

      // reset mid-LOAD after three beats
      start_tile(2);
      for (int b = 0; b < 3; b++) send_beat(b, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      expect_tile(2, 28, 1'b0, 2'b01);
      start_tile(2);
      send_tile(7, 1'b0);
      wait_drain("after_reset_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wgt_loader.md
Name: wgt_loader

Overview:
- Producer side of the double-buffered weight SRAM: drives its DMA write port (we/waddr/wdata/bank_sel_wr).
- Accepts a byte-packed weight stream from the DMA engine (valid/ready, IN_BYTES per beat) and repacks it into TN-byte rows.
- Writes one tile of cfg_rows rows per start into the next free ping-pong bank.
- Tracks bank ownership with the systolic-array controller via bank_valid/bank_release.

Parameters:
TN, 14, bytes per weight row (wdata width = TN*8)
ADDR_WIDTH, 7, row address width; max tile = 2^ADDR_WIDTH rows
IN_BYTES, 4, bytes per input stream beat (1..TN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: load one tile (ignored unless idle)
cfg_rows  in  ADDR_WIDTH+1  rows in tile, sampled at start; 1..2^ADDR_WIDTH, 0 treated as 1
s_valid  in  1  stream beat valid
s_ready  out  1  stream beat accepted when s_valid&s_ready
s_data  in  IN_BYTES*8  beat bytes, byte0 = bits[7:0]
s_last  in  1  final beat of tile
we  out  1  row write strobe
waddr  out  ADDR_WIDTH  row address
wdata  out  TN*8  row data, stream byte order LSB first
bank_sel_wr  out  1  target bank
bank_valid  out  2  bank i holds a complete tile
bank_release  in  2  pulse: consumer frees bank i
busy  out  1  not IDLE
done  out  1  one-cycle pulse at tile completion
err_short  out  1  sticky: s_last before cfg_rows*TN bytes; cleared on start
err_long  out  1  sticky: bytes beyond cfg_rows*TN dropped; cleared on start

Behaviour:
- Reset: all outputs 0, state IDLE, write-bank pointer 0, bank_valid 00, packer empty.
- Reset asserted mid-tile aborts the tile; no partial bank_valid is set.
- All outputs are registered except s_ready, which is decoded from state and count.
- FSM states:
  - IDLE: start -> WAIT_BANK. Latch cfg_rows, clear errors, waddr = 0.
  - WAIT_BANK: if bank_valid[ptr] = 0, go to LOAD; otherwise stall until bank_release[ptr].
  - LOAD: packing, described below.
  - FLUSH: one cycle; write the zero-padded partial row if any, then go to DONE.
  - DONE: set bank_valid[ptr], pulse done, toggle ptr, go to IDLE.
- Packer:
  - Byte accumulator of TN+IN_BYTES-1 bytes with count cnt.
  - s_ready = LOAD && cnt < TN.
  - An accepted beat appends IN_BYTES bytes at position cnt.
  - When cnt >= TN and rows written < cfg_rows: next cycle we=1, wdata = low TN bytes, waddr = row index; the accumulator shifts down by TN; cnt -= TN; row index += 1.
  - A row may span beats; leftover bytes carry into the next row.
  - Row write and beat acceptance never occur in the same cycle.
- Tile end:
  - Accepted s_last with exact byte count: after the last row write, go to DONE.
  - s_last short: set err_short. Go to FLUSH if cnt > 0; the partial row is written with zeros above cnt. Later rows are not written.
  - Rows complete before s_last: stay in LOAD with s_ready=1, discard beats, set err_long, go to DONE on s_last.
- bank_release[i] clears bank_valid[i] the next cycle.
  - Release of the bank being set in DONE in the same cycle: set wins.
  - Release of a bank with bank_valid = 0 is ignored.
- bank_sel_wr = ptr throughout the tile.
- Latency: row write one cycle after the completing beat; done/bank_valid one cycle after the final write.

Optional Feature:
- WGT_LOADER_CKSUM_EN defined: adds output cksum [31:0], the mod-2^32 sum of all bytes written (pad zeros included) in the last completed tile. Valid from the done pulse until the next done; reset 0.
- Undefined: port and adder absent.

Decomposition:
- Package wgt_loader_pkg: FSM state enum (IDLE, WAIT_BANK, LOAD, FLUSH, DONE) and localparam ACC_BYTES = TN+IN_BYTES-1.
- One sub-module, wgt_row_packer: byte accumulator, cnt, shift/emit logic. The FSM, bank tracking and error flags stay in top.

Test Plan (TN=14, IN_BYTES=4, ADDR_WIDTH=7):
- Exact tile: start, cfg_rows=2, 7 beats bytes 0x00..0x1B, last on beat 7 -> writes waddr 0 (bytes 00..0D) and waddr 1 (0E..1B), bank_sel_wr=0, then bank_valid=01 and done pulse, no errors.
- Ping-pong stall: repeat tile -> bank 1, bank_valid=11. Third start -> busy, s_ready=0 stalls. Pulse bank_release[0] -> loads into bank 0.
- Short tile: cfg_rows=2, s_last on beat 5 (20 bytes) -> row1 = bytes 0E..13 then 8 zero bytes, err_short=1, done.
- Long tile plus backpressure: cfg_rows=1, 6 beats with random s_valid gaps -> one write of bytes 00..0D, remaining bytes dropped, err_long=1, done after s_last.
- Simultaneous set/release: release[ptr] pulsed in DONE cycle -> bank_valid[ptr]=1.
- Reset mid-LOAD after 3 beats -> all outputs 0, bank_valid=00; next full tile writes bank 0 from waddr 0 correctly.
